// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB       = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    // Width of an index or counter able to hold values 0..n-1, never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin first-valid search: the lowest-numbered valid requester at or
// after ptr (wrapping) wins.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               found
);

    logic [NUM_REQ-1:0] rot_s;
    logic [NUM_REQ-1:0] pick_s;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot_s  = NUM_REQ'({valid, valid} >> ptr);
        pick_s = rot_s & (~rot_s + {{(NUM_REQ-1){1'b0}}, 1'b1});
        gnt    = NUM_REQ'(({pick_s, pick_s} << ptr) >> NUM_REQ);
        found  = |valid;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter between NUM_REQ requesters; a granted
// requester keeps the transmitter until its last byte or a hold timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int HOLD_TIMEOUT  = 65535,
    parameter int BUSY_WAIT_MAX = 15
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_din,
    output logic                 tx_wr_en,
    input  logic                 tx_busy,
    output logic                 abort_pulse
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int HC_W  = idx_width(HOLD_TIMEOUT + 1);
    localparam int BC_W  = idx_width(BUSY_WAIT_MAX + 1);

    state_e             state_q,    state_d;
    logic [NUM_REQ-1:0] grant_q,    grant_d;
    logic [IDX_W-1:0]   owner_q,    owner_d;
    logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [7:0]         tx_din_q,   tx_din_d;
    logic               tx_wr_en_q, tx_wr_en_d;
    logic               abort_q,    abort_d;
    logic               last_q,     last_d;
    logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [BC_W-1:0]    busy_cnt_q, busy_cnt_d;

    logic [NUM_REQ-1:0] pick_gnt_s;
    logic               pick_found_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               owner_valid_s;
    logic               owner_last_s;
    logic [7:0]         owner_data_s;
    logic [IDX_W-1:0]   next_ptr_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .gnt   (pick_gnt_s),
        .found (pick_found_s)
    );

    // Encode the picked one-hot and mux out the current owner's request lanes.
    always_comb begin
        pick_idx_s    = {IDX_W{1'b0}};
        owner_valid_s = 1'b0;
        owner_last_s  = 1'b0;
        owner_data_s  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_idx_s    = pick_gnt_s[i] ? IDX_W'(i) : pick_idx_s;
            owner_valid_s = (owner_q == IDX_W'(i)) ? req_valid[i] : owner_valid_s;
            owner_last_s  = (owner_q == IDX_W'(i)) ? req_last[i] : owner_last_s;
            owner_data_s  = (owner_q == IDX_W'(i)) ? req_data[8*i +: 8] : owner_data_s;
        end
        next_ptr_s = (owner_q == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : owner_q + IDX_W'(1);
    end

    // Next-state logic; strobe and abort default low so each lasts one cycle.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        tx_din_d   = tx_din_q;
        tx_wr_en_d = 1'b0;
        abort_d    = 1'b0;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        busy_cnt_d = busy_cnt_q;
        case (state_q)
            ARB: begin
                if (!tx_busy && pick_found_s) begin
                    grant_d    = pick_gnt_s;
                    owner_d    = pick_idx_s;
                    hold_cnt_d = {HC_W{1'b0}};
                    state_d    = ISSUE;
                end else begin
                    grant_d = {NUM_REQ{1'b0}};
                end
            end
            ISSUE: begin
                if (owner_valid_s) begin
                    tx_din_d   = owner_data_s;
                    tx_wr_en_d = 1'b1;
                    last_d     = owner_last_s;
                    busy_cnt_d = {BC_W{1'b0}};
                    state_d    = WAIT_BUSY;
                end else if (hold_cnt_q == HC_W'(HOLD_TIMEOUT - 1)) begin
                    grant_d  = {NUM_REQ{1'b0}};
                    rr_ptr_d = next_ptr_s;
                    abort_d  = 1'b1;
                    state_d  = ARB;
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            WAIT_BUSY: begin
                // Bounded so a strobe the transmitter never saw cannot stall us.
                if (tx_busy || (busy_cnt_q == BC_W'(BUSY_WAIT_MAX - 1))) begin
                    state_d = WAIT_DONE;
                end else begin
                    busy_cnt_d = busy_cnt_q + BC_W'(1);
                end
            end
            WAIT_DONE: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (last_q) begin
                    grant_d  = {NUM_REQ{1'b0}};
                    rr_ptr_d = next_ptr_s;
                    state_d  = ARB;
                end else begin
                    hold_cnt_d = {HC_W{1'b0}};
                    state_d    = ISSUE;
                end
            end
            default: begin
                grant_d = {NUM_REQ{1'b0}};
                state_d = ARB;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ARB;
            grant_q    <= {NUM_REQ{1'b0}};
            owner_q    <= {IDX_W{1'b0}};
            rr_ptr_q   <= {IDX_W{1'b0}};
            tx_din_q   <= 8'h00;
            tx_wr_en_q <= 1'b0;
            abort_q    <= 1'b0;
            last_q     <= 1'b0;
            hold_cnt_q <= {HC_W{1'b0}};
            busy_cnt_q <= {BC_W{1'b0}};
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_din_q   <= tx_din_d;
            tx_wr_en_q <= tx_wr_en_d;
            abort_q    <= abort_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign req_ready   = (state_q == ISSUE) ? grant_q : {NUM_REQ{1'b0}};
    assign grant       = grant_q;
    assign tx_din      = tx_din_q;
    assign tx_wr_en    = tx_wr_en_q;
    assign abort_pulse = abort_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART byte transmitter between NUM_REQ on-chip requesters, e.g. HID report dumper, debug console and status beacon.
- Messages are multi-byte and delimited by a last flag. Once a requester is granted, it keeps the transmitter until its last byte, so messages never interleave.
- Grants are round-robin between messages.
- A hold timeout reclaims the transmitter from a requester that stalls mid-message.
- Sits between the requesters and the transmitter's din / wr_en / tx_busy interface.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- HOLD_TIMEOUT, 65535, idle cycles a locked owner may withhold its next byte before the lock is dropped (>=1).
- BUSY_WAIT_MAX, 15, cycles to wait for tx_busy to rise after a write before proceeding anyway (>=2).

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous assert, active low
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  NUM_REQ  byte is final of message; qualified by valid
- req_ready  out  NUM_REQ  byte accepted when valid&ready
- grant  out  NUM_REQ  one-hot current owner; zero when unowned
- tx_din  out  8  byte to transmitter
- tx_wr_en  out  1  one-cycle write strobe to transmitter
- tx_busy  in  1  transmitter busy
- abort_pulse  out  1  one-cycle pulse when a lock is dropped by timeout

Behaviour:
- Clock and reset: one clock `clk`; reset is asynchronous and active-low (`resetn`).
- Reset values:
  - state=ARB; grant=0; rr_ptr=0; tx_din=0; tx_wr_en=0; abort_pulse=0; hold_cnt=0; busy_cnt=0.
  - req_ready is 0 because it is decoded from state.
  - Reset mid-byte drops everything immediately. The transmitter finishes its byte independently, and the arbiter ignores that tail.
- States: ARB, ISSUE, WAIT_BUSY, WAIT_DONE.
- ARB:
  - If tx_busy=1, stay in ARB.
  - Otherwise search requesters rr_ptr, rr_ptr+1, … modulo NUM_REQ for the first with req_valid=1.
  - If one is found: grant<=onehot(i), hold_cnt<=0, go ISSUE.
  - If none: stay, grant stays 0.
- ISSUE:
  - req_ready[i] = (state==ISSUE) & grant[i], decoded combinationally. All other ready bits are 0.
  - If req_valid[owner]=1: tx_din<=req_data[owner], tx_wr_en<=1 for exactly one cycle, latch last_q<=req_last[owner], busy_cnt<=0, go WAIT_BUSY.
  - If req_valid[owner]=0: hold_cnt++.
    - When hold_cnt reaches HOLD_TIMEOUT-1: grant<=0, rr_ptr<=owner+1 mod NUM_REQ, abort_pulse<=1, go ARB.
- WAIT_BUSY (absorbs the transmitter's latency before busy asserts):
  - tx_busy=1 → go WAIT_DONE.
  - Otherwise busy_cnt++. At BUSY_WAIT_MAX, go WAIT_DONE anyway. This guards a lost strobe so the arbiter never deadlocks.
- WAIT_DONE: wait for tx_busy=0, then:
  - If last_q=1: grant<=0, rr_ptr<=owner+1 mod NUM_REQ, go ARB.
  - If last_q=0: hold_cnt<=0, go ISSUE with the same owner.
- Throughput and latency:
  - At most one byte is in flight, and one tx_wr_en pulse is issued per accepted byte.
  - Minimum latency from valid to tx_wr_en is 2 cycles from ARB: ARB→ISSUE, then ISSUE edge registers the strobe.
  - Back-to-back bytes have no added gap beyond 2 cycles after tx_busy falls.
- Boundary conditions:
  - Single-byte messages (last on the first byte) are legal.
  - A requester dropping valid without last is handled by the timeout.
  - Valid changes by non-owners are ignored while locked.
  - After a timeout, the dropped requester's remaining bytes are treated as a new message.
- Owner index is encoded as clog2(NUM_REQ) bits, minimum 1.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants ARB=2'd0, ISSUE=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3;
  - clog2-derived index width helper.
- One sub-module, rr_pick: combinational round-robin first-valid search.
  - Inputs: valid vector and pointer.
  - Outputs: one-hot grant and found flag.

Test Plan:
- Single requester: req0 sends message 0x41,0x42(last) with a transmitter model (busy 1 cycle after wr_en, 87 cycles long) → two tx_wr_en pulses with tx_din 0x41 then 0x42; grant=001 throughout, 0 after.
- Contention: req0 and req1 both valid at reset exit, each sending 3-byte messages → wire order r0 0x10,0x11,0x12 then r1 0x20,0x21,0x22. No interleave; rr_ptr=2 after r1.
- Fairness: all three requesters continuously send 1-byte messages → grant order 0,1,2,0,1,2; each gets exactly 1 byte per round.
- Hold timeout with HOLD_TIMEOUT=8: req1 sends 0x55 (not last) then drops valid → abort_pulse exactly once, 8 cycles into ISSUE idle; grant then moves to waiting req2.
- Lost strobe: transmitter model ignores one wr_en (busy stays 0) → after BUSY_WAIT_MAX cycles the arbiter proceeds; next byte is issued with no hang.
- Async reset asserted mid-transmission in WAIT_DONE → all outputs reset immediately, without waiting for a clock edge. After release and tx_busy falling, a new request on req2 is granted.
